// File: rtl/clock_div_ctrl_if.sv
// rtl/clock_div_ctrl_if.sv - reconfiguration request/response bundle for clock_div_ctrl
// The requester drives the request fields; the controller answers with ready/done/err.
interface clock_div_ctrl_if;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_half;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_half,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/clock_div_ctrl.sv
// rtl/clock_div_ctrl.sv - three-channel programmable clock divider with boundary-synchronous reconfiguration
// Half-period changes are applied only at a channel's toggle boundary so no phase is cut short or stretched.
module clock_div_ctrl #(
  parameter logic [15:0] HALF0 = 16'd2500,
  parameter logic [15:0] HALF1 = 16'd500,
  parameter logic [15:0] HALF2 = 16'd658
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [2:0]       ch_en,
  clock_div_ctrl_if.slave  cfg,
  output logic [2:0]       clk_out,
  output logic [2:0]       tick
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [1:0]  req_ch_q;
  logic [15:0] req_half_q;
  logic        req_err_q;

  logic [15:0] half_q [3];
  logic [15:0] cnt_q  [3];

  logic [2:0]  boundary;
  logic        accept;
  logic        pend_hit;
  logic        commit;

  always_comb begin
    boundary = 3'b000;
    for (int i = 0; i < 3; i++) begin
      boundary[i] = ch_en[i] && (cnt_q[i] == half_q[i] - 16'd1);
    end
  end

  assign accept = cfg.cfg_valid && (state_q == IDLE);

  // A disabled target has cnt held at 0, so committing immediately cannot overshoot.
  always_comb begin
    pend_hit = 1'b0;
    case (req_ch_q)
      2'd0:    pend_hit = !ch_en[0] || boundary[0];
      2'd1:    pend_hit = !ch_en[1] || boundary[1];
      2'd2:    pend_hit = !ch_en[2] || boundary[2];
      default: pend_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (cfg.cfg_ch == 2'd3) ? DONE : PEND;
        end
      end
      PEND: begin
        if (pend_hit) begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      req_ch_q   <= 2'd0;
      req_half_q <= 16'd1;
      req_err_q  <= 1'b0;
    end else if (accept) begin
      req_ch_q   <= cfg.cfg_ch;
      req_half_q <= (cfg.cfg_half == 16'd0) ? 16'd1 : cfg.cfg_half;
      req_err_q  <= (cfg.cfg_ch == 2'd3);
    end
  end

  assign cfg.cfg_ready = (state_q == IDLE);
  assign cfg.cfg_done  = (state_q == DONE);
  assign cfg.cfg_err   = (state_q == DONE) && req_err_q;

  // The boundary toggle below still compares against the old half; the new one governs the next phase.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      half_q[0] <= HALF0;
      half_q[1] <= HALF1;
      half_q[2] <= HALF2;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= 16'd0;
      end
      clk_out <= 3'b000;
      tick    <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (commit && (req_ch_q == i[1:0])) begin
          half_q[i] <= req_half_q;
        end
        if (!ch_en[i]) begin
          cnt_q[i]   <= 16'd0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (boundary[i]) begin
          cnt_q[i]   <= 16'd0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= 1'b1;
        end else begin
          cnt_q[i]   <= cnt_q[i] + 16'd1;
          tick[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb/tb_clock_div_ctrl.sv - scoreboard bench for clock_div_ctrl
// Requests push the expected cfg_err into a queue; a negedge monitor pops on cfg_done and tracks tick spacing.
module tb_clock_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ch_en = 3'b000;
  logic [2:0] clk_out;
  logic [2:0] tick;

  clock_div_ctrl_if cfg_if ();

  clock_div_ctrl dut (
    .clk_in  (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  bit exp_q[$];
  int done_count = 0;
  int done_cyc = 0;
  bit prev_done = 1'b0;
  int xfer_cyc = 0;

  int tick_cnt [3] = '{0, 0, 0};
  int last_tick[3] = '{0, 0, 0};
  int gap      [3] = '{0, 0, 0};
  bit seen     [3] = '{0, 0, 0};

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int req, input int tol);
    compared++;
    if (act < req - tol || act > req + tol) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d +-%0d", name, act, req, tol);
    end
  endtask

  always @(negedge clk) begin
    if (prev_done) check("done_width", int'(cfg_if.cfg_done), 0);
    if (cfg_if.cfg_err) check("err_with_done", int'(cfg_if.cfg_done), 1);
    if (cfg_if.cfg_done) begin
      check("done_expected", exp_q.size(), 1);
      if (exp_q.size() > 0) check("done_err", int'(cfg_if.cfg_err), int'(exp_q.pop_front()));
      done_count++;
      done_cyc = cyc;
    end
    prev_done = cfg_if.cfg_done;
    for (int i = 0; i < 3; i++) begin
      if (tick[i]) begin
        if (seen[i]) gap[i] = cyc - last_tick[i];
        last_tick[i] = cyc;
        seen[i] = 1'b1;
        tick_cnt[i]++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int ch, input int n);
    int target;
    target = tick_cnt[ch] + n;
    for (int k = 0; k < 6000; k++) begin
      if (tick_cnt[ch] >= target) break;
      step();
    end
    check("tick_wait", int'(tick_cnt[ch] >= target), 1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 6000; k++) begin
      if (done_count >= target) break;
      step();
    end
    check("done_wait", int'(done_count >= target), 1);
  endtask

  task automatic do_req(input logic [1:0] ch, input logic [15:0] half, input bit push, input bit err);
    bit ok;
    ok = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_half  = half;
    for (int k = 0; k < 6000; k++) begin
      if (cfg_if.cfg_ready) begin
        xfer_cyc = cyc;
        if (push) exp_q.push_back(err);
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    check("req_accept", int'(ok), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int s0, s1, s2;
    int d0;
    bit a;
    bit took;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_half  = 16'd0;
    repeat (3) step();

    check("rst_ready", int'(cfg_if.cfg_ready), 1);
    check("rst_done", int'(cfg_if.cfg_done), 0);
    check("rst_err", int'(cfg_if.cfg_err), 0);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);

    // Free-running defaults for 20000 cycles.
    s0 = tick_cnt[0]; s1 = tick_cnt[1]; s2 = tick_cnt[2];
    ch_en = 3'b111;
    rst_n = 1'b1;
    r = cyc;
    repeat (20000) step();
    check_tol("ch0_ticks", tick_cnt[0] - s0, 8, 1);
    check_tol("ch1_ticks", tick_cnt[1] - s1, 40, 1);
    check_tol("ch2_ticks", tick_cnt[2] - s2, 30, 1);
    check("ch0_last_tick", last_tick[0] - r, 20000);
    check("ch2_last_tick", last_tick[2] - r, 19740);
    check("ch0_half", gap[0], 2500);
    check("ch1_half", gap[1], 500);
    check("ch2_half", gap[2], 658);

    // Channel 1 -> 100, committed at its next boundary.
    d0 = done_count;
    do_req(2'd1, 16'd100, 1'b1, 1'b0);
    check("pend_ready_low", int'(cfg_if.cfg_ready), 0);
    wait_done(d0 + 1);
    check("ch1_commit_at_boundary", last_tick[1], done_cyc);
    check("ch1_commit_old_half", gap[1], 500);
    step();
    check("ready_after_done", int'(cfg_if.cfg_ready), 1);
    wait_ticks(1, 2);
    check("ch1_new_half", gap[1], 100);

    // Invalid channel: done+err one cycle after transfer, nothing changes.
    d0 = done_count;
    do_req(2'd3, 16'h1234, 1'b1, 1'b1);
    wait_done(d0 + 1);
    check("err_latency", done_cyc - xfer_cyc, 1);
    wait_ticks(1, 1);
    check("ch1_unaffected", gap[1], 100);
    wait_ticks(2, 1);
    check("ch2_unaffected", gap[2], 658);

    // Disabled channel 2, half 0 stored as 1.
    ch_en = 3'b011;
    repeat (2) step();
    check("ch2_off_clk", int'(clk_out[2]), 0);
    check("ch2_off_tick", int'(tick[2]), 0);
    d0 = done_count;
    do_req(2'd2, 16'd0, 1'b1, 1'b0);
    wait_done(d0 + 1);
    check("disabled_commit_latency", done_cyc - xfer_cyc, 2);
    ch_en = 3'b111;
    r = cyc;
    wait_ticks(2, 1);
    check("ch2_first_toggle", last_tick[2] - r, 1);
    wait_ticks(2, 2);
    check("ch2_half_one", gap[2], 1);
    a = clk_out[2];
    step();
    check("ch2_toggles", int'(clk_out[2]), int'(!a));

    // Hold valid with a churning half while busy; only the accepting value counts.
    d0 = done_count;
    do_req(2'd1, 16'd60, 1'b1, 1'b0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd1;
    took = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (cfg_if.cfg_ready) begin
        cfg_if.cfg_half = 16'd30;
        exp_q.push_back(1'b0);
        took = 1'b1;
        step();
        break;
      end
      cfg_if.cfg_half = 16'(cyc) ^ 16'h5a5a;
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    check("held_req_accept", int'(took), 1);
    wait_done(d0 + 2);
    check("ch1_second_commit_at_boundary", last_tick[1], done_cyc);
    check("ch1_half_60", gap[1], 60);
    wait_ticks(1, 2);
    check("ch1_half_30", gap[1], 30);

    // Reset while pending on channel 0 discards the request.
    wait_ticks(0, 1);
    do_req(2'd0, 16'd50, 1'b0, 1'b0);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("rst_pend_ready", int'(cfg_if.cfg_ready), 1);
    check("rst_pend_done", int'(cfg_if.cfg_done), 0);
    check("rst_pend_clk_out", int'(clk_out), 0);
    repeat (3) step();
    rst_n = 1'b1;
    r = cyc;
    wait_ticks(0, 1);
    check("ch0_first_after_rst", last_tick[0] - r, 2500);
    wait_ticks(0, 1);
    check("ch0_half_restored", gap[0], 2500);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
